// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, FSM states and defaults
package uart_pkg;

    // Parity selection encodings
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Defaults shared with the receiver: 50 MHz clock, 19200 baud, 8 data bits
    localparam int DEF_CNT_MAX = 2604;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    // Narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        calc_parity = (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO with registered count and ready
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, count and ready; ready looks at the post-edge occupancy so a
    // pop never makes a full FIFO ready within the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            rdy   <= (count_next < DEPTH_C);
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with FIFO, configurable parity and stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int CNT_MAX    = DEF_CNT_MAX,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic              dout,
    output logic              busy
);

    localparam int CNT_W = $clog2(CNT_MAX);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [CNT_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;

    logic              bit_done;
    logic              last_data;
    logic              last_stop;
    logic              shift_en;
    logic              dout_next;
    logic              busy_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    // Ready implies not full; the extra full term keeps the FIFO safe on its own
    assign fifo_push = din_vld && din_rdy && !fifo_full;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rdy       (din_rdy)
    );

    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign last_data = (bit_cnt == DATA_LAST);
    assign last_stop = (bit_cnt == STOP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the last stop bit chains straight into the next start
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_next = ST_START;
            end
            ST_START: begin
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && last_data) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done && last_stop) begin
                    state_next = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pop, shift and next line value, all derived from the transition taken
    always_comb begin
        fifo_pop = ((state == ST_IDLE) && !fifo_empty) ||
                   ((state == ST_STOP) && bit_done && last_stop && !fifo_empty);
        shift_en = ((state == ST_START) && bit_done) ||
                   ((state == ST_DATA) && bit_done && !last_data);
        dout_next = dout;
        case (state_next)
            ST_IDLE:   dout_next = 1'b1;
            ST_START:  dout_next = 1'b0;
            ST_DATA:   if (shift_en) dout_next = shift_reg[0];
            ST_PARITY: dout_next = parity_bit;
            ST_STOP:   dout_next = 1'b1;
            default:   dout_next = 1'b1;
        endcase
        // Heading to IDLE means nothing was queued and nothing popped, so the
        // post-edge occupancy is non-zero only if a word is pushed now
        busy_next = (state_next != ST_IDLE) || fifo_push;
    end

    // Baud counter, bit counter, shift register and latched parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if ((state == ST_IDLE) || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (fifo_pop) begin
                shift_reg  <= fifo_dout;
                parity_bit <= calc_parity(8'(fifo_dout), PARITY);
            end else if (shift_en) begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

    // Registered line and busy outputs; reset forces the line idle at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 1'b1;
            busy <= 1'b0;
        end else begin
            dout <= dout_next;
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic clk;
    logic rst_n;

    logic [7:0] din_a, din_e, din_o, din_s;
    logic       vld_a, vld_e, vld_o, vld_s;
    logic       rdy_a, rdy_e, rdy_o, rdy_s;
    logic       dout_a, dout_e, dout_o, dout_s;
    logic       busy_a, busy_e, busy_o, busy_s;

    int checks = 0;
    int errors = 0;

    uart_tx #(.CNT_MAX(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_base (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_vld(vld_a),
        .din_rdy(rdy_a), .dout(dout_a), .busy(busy_a));

    uart_tx #(.CNT_MAX(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst_n(rst_n), .din(din_e), .din_vld(vld_e),
        .din_rdy(rdy_e), .dout(dout_e), .busy(busy_e));

    uart_tx #(.CNT_MAX(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .din(din_o), .din_vld(vld_o),
        .din_rdy(rdy_o), .dout(dout_o), .busy(busy_o));

    uart_tx #(.CNT_MAX(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .din(din_s), .din_vld(vld_s),
        .din_rdy(rdy_s), .dout(dout_s), .busy(busy_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din_a = 8'h00; din_e = 8'h00; din_o = 8'h00; din_s = 8'h00;
        vld_a = 1'b0; vld_e = 1'b0; vld_o = 1'b0; vld_s = 1'b0;
        repeat (3) tick();
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL reset_dout: got %b expected 1", dout_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (dout_s !== 1'b1) begin errors++; $display("FAIL reset_dout_stop2: got %b expected 1", dout_s); end
        rst_n = 1'b1;
        tick();
        checks++; if ({rdy_a, rdy_e, rdy_o, rdy_s} !== 4'b1111) begin errors++; $display("FAIL release_rdy: got %b expected 1111", {rdy_a, rdy_e, rdy_o, rdy_s}); end
        checks++; if (busy_a !== 1'b0 || dout_a !== 1'b1) begin errors++; $display("FAIL release_idle: got busy=%b dout=%b expected busy=0 dout=1", busy_a, dout_a); end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        exp = {1'b1, 8'h55, 1'b0};
        din_a = 8'h55; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_push: got %b expected 1", busy_a); end
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL single_pre_start: got %b expected 1", dout_a); end
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dout_a !== exp[i/4]) begin errors++; $display("FAIL single_line[%0d]: got %b expected %b", i, dout_a, exp[i/4]); end
        end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", busy_a); end
        tick();
        checks++; if (dout_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL single_end: got dout=%b busy=%b expected dout=1 busy=0", dout_a, busy_a); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp;
        exp = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
        din_a = 8'hA3; vld_a = 1'b1;
        tick();
        din_a = 8'h0F;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (i == 0) din_a = 8'hFF;
            if (i == 1) vld_a = 1'b0;
            checks++;
            if (dout_a !== exp[i/4]) begin errors++; $display("FAIL b2b_line[%0d]: got %b expected %b", i, dout_a, exp[i/4]); end
        end
        tick();
        checks++; if (dout_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL b2b_end: got dout=%b busy=%b expected dout=1 busy=0", dout_a, busy_a); end
    endtask

    task automatic test_backpressure();
        logic line_log [0:259];
        logic rdy_log  [0:259];
        logic [7:0] exp_words [0:5];
        logic [9:0] got;
        logic [9:0] exp;
        logic acc_this;
        int accepted;
        int acc_at_10;
        exp_words = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        accepted = 0;
        acc_at_10 = 0;
        din_a = 8'h10; vld_a = 1'b1;
        for (int i = 0; i < 260; i++) begin
            acc_this = rdy_a && vld_a;
            tick();
            if (acc_this) begin
                accepted++;
                din_a = din_a + 8'd1;
            end
            if (accepted == 6) vld_a = 1'b0;
            line_log[i] = dout_a;
            rdy_log[i]  = rdy_a;
            if (i == 10) acc_at_10 = accepted;
        end
        checks++; if (acc_at_10 != 5) begin errors++; $display("FAIL bp_accept_count: got %0d expected 5", acc_at_10); end
        checks++; if (rdy_log[10] !== 1'b0) begin errors++; $display("FAIL bp_rdy_full: got %b expected 0", rdy_log[10]); end
        checks++; if (rdy_log[40] !== 1'b0) begin errors++; $display("FAIL bp_rdy_before_pop: got %b expected 0", rdy_log[40]); end
        checks++; if (rdy_log[41] !== 1'b1) begin errors++; $display("FAIL bp_rdy_after_pop: got %b expected 1", rdy_log[41]); end
        checks++; if (accepted != 6) begin errors++; $display("FAIL bp_total_accepted: got %0d expected 6", accepted); end
        for (int f = 0; f < 6; f++) begin
            exp = {1'b1, exp_words[f], 1'b0};
            for (int b = 0; b < 10; b++) got[b] = line_log[1 + f*40 + b*4 + 2];
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bp_frame[%0d]: got %b expected %b", f, got, exp); end
        end
        checks++; if (line_log[245] !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL bp_end: got dout=%b busy=%b expected dout=1 busy=0", line_log[245], busy_a); end
    endtask

    task automatic test_parity();
        logic log_e [0:43];
        logic log_o [0:43];
        logic [10:0] got_e, got_o;
        logic [10:0] exp_e, exp_o;
        exp_e = {1'b1, 1'b1, 8'h07, 1'b0};
        exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
        din_e = 8'h07; din_o = 8'h07; vld_e = 1'b1; vld_o = 1'b1;
        tick();
        vld_e = 1'b0; vld_o = 1'b0;
        for (int i = 0; i < 44; i++) begin
            tick();
            log_e[i] = dout_e;
            log_o[i] = dout_o;
        end
        checks++; if (busy_e !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL par_busy_last: got even=%b odd=%b expected 1 1", busy_e, busy_o); end
        tick();
        checks++; if ({dout_e, busy_e, dout_o, busy_o} !== 4'b1010) begin errors++; $display("FAIL par_end: got %b expected 1010", {dout_e, busy_e, dout_o, busy_o}); end
        for (int b = 0; b < 11; b++) begin
            got_e[b] = log_e[b*4 + 2];
            got_o[b] = log_o[b*4 + 2];
        end
        checks++; if (got_e[9] !== 1'b1) begin errors++; $display("FAIL par_even_bit: got %b expected 1", got_e[9]); end
        checks++; if (got_o[9] !== 1'b0) begin errors++; $display("FAIL par_odd_bit: got %b expected 0", got_o[9]); end
        checks++; if (got_e !== exp_e) begin errors++; $display("FAIL par_even_frame: got %b expected %b", got_e, exp_e); end
        checks++; if (got_o !== exp_o) begin errors++; $display("FAIL par_odd_frame: got %b expected %b", got_o, exp_o); end
    endtask

    task automatic test_stop2();
        logic log_s [0:87];
        logic [10:0] got, exp;
        logic [7:0] words [0:1];
        int high_bad;
        words = '{8'h81, 8'h3C};
        din_s = 8'h81; vld_s = 1'b1;
        tick();
        din_s = 8'h3C;
        for (int i = 0; i < 88; i++) begin
            tick();
            if (i == 0) vld_s = 1'b0;
            log_s[i] = dout_s;
        end
        high_bad = 0;
        for (int i = 36; i < 44; i++) if (log_s[i] !== 1'b1) high_bad++;
        checks++; if (high_bad != 0) begin errors++; $display("FAIL stop2_gap_high: got %0d low samples expected 0", high_bad); end
        checks++; if (log_s[44] !== 1'b0) begin errors++; $display("FAIL stop2_next_start: got %b expected 0", log_s[44]); end
        for (int f = 0; f < 2; f++) begin
            exp = {2'b11, words[f], 1'b0};
            for (int b = 0; b < 11; b++) got[b] = log_s[f*44 + b*4 + 2];
            checks++;
            if (got !== exp) begin errors++; $display("FAIL stop2_frame[%0d]: got %b expected %b", f, got, exp); end
        end
        tick();
        checks++; if (dout_s !== 1'b1 || busy_s !== 1'b0) begin errors++; $display("FAIL stop2_end: got dout=%b busy=%b expected dout=1 busy=0", dout_s, busy_s); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        din_a = 8'hF0; vld_a = 1'b1;
        tick();
        din_a = 8'h11;
        tick();
        din_a = 8'h22;
        tick();
        vld_a = 1'b0;
        repeat (16) tick();
        checks++; if (dout_a !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b expected 0", dout_a); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL rstmid_async_dout: got %b expected 1", dout_a); end
        checks++; if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_async_flags: got rdy=%b busy=%b expected 0 0", rdy_a, busy_a); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rstmid_rdy_release: got %b expected 1", rdy_a); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dout_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_no_frames: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_parity();
        test_stop2();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
